// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Mode codes 5..7 are illegal and travel through the pipe as an error flag.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_ROR = 3'd0,
        MODE_ROL = 3'd1,
        MODE_LSR = 3'd2,
        MODE_LSL = 3'd3,
        MODE_ASR = 3'd4
    } shift_mode_t;

    localparam int MODE_W = 3;

    function automatic logic mode_is_illegal(input logic [MODE_W-1:0] mode);
        return mode > 3'd4;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered pipeline stage: conditionally applies a shift of STEP bits
// (selected by amount bit log2(STEP)) and holds the word until downstream takes it.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prev_valid,
    input  logic [WIDTH-1:0]  prev_data,
    input  logic [AMT_W-1:0]  prev_amt,
    input  logic [MODE_W-1:0] prev_mode,
    input  logic              prev_err,
    input  logic              next_take,
    output logic              load,
    output logic              valid,
    output logic [WIDTH-1:0]  data,
    output logic [AMT_W-1:0]  amt,
    output logic [MODE_W-1:0] mode,
    output logic              err
);

    localparam int BIT = $clog2(STEP);

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [AMT_W-1:0]  amt;
        logic [MODE_W-1:0] mode;
        logic              err;
    } payload_t;

    payload_t payload_q;
    payload_t payload_d;
    logic     valid_q;

    // ASR fill uses the current MSB; earlier ASR steps never change it.
    function automatic logic [WIDTH-1:0] step_shift(input logic [WIDTH-1:0] x,
                                                    input logic [MODE_W-1:0] m);
        logic [WIDTH-1:0] sign_fill;
        sign_fill = {WIDTH{x[WIDTH-1]}} << (WIDTH - STEP);
        case (m)
            MODE_ROR: return (x >> STEP) | (x << (WIDTH - STEP));
            MODE_ROL: return (x << STEP) | (x >> (WIDTH - STEP));
            MODE_LSR: return x >> STEP;
            MODE_LSL: return x << STEP;
            MODE_ASR: return (x >> STEP) | sign_fill;
            default:  return x;
        endcase
    endfunction

    always_comb begin
        payload_d.data = prev_data;
        payload_d.amt  = prev_amt;
        payload_d.mode = prev_mode;
        payload_d.err  = prev_err;
        if (prev_amt[BIT]) begin
            payload_d.data = step_shift(prev_data, prev_mode);
        end
    end

    assign load = !valid_q || next_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            if (load) begin
                valid_q <= prev_valid;
            end
            if (load && prev_valid) begin
                payload_q <= payload_d;
            end
        end
    end

    assign valid = valid_q;
    assign data  = payload_q.data;
    assign amt   = payload_q.amt;
    assign mode  = payload_q.mode;
    assign err   = payload_q.err;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: AMT_W power-of-two stages with valid/ready handshake,
// bubble collapsing and full backpressure. Output comes straight from the last stage.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_err
);

    // Index 0 is the input side; index k+1 is the output of stage k.
    logic [AMT_W:0]    v_s;
    logic [AMT_W:0]    err_s;
    logic [WIDTH-1:0]  data_s [AMT_W+1];
    logic [AMT_W-1:0]  amt_s  [AMT_W+1];
    logic [MODE_W-1:0] mode_s [AMT_W+1];
    logic              in_illegal;
    logic              unused_tail;

    assign in_illegal = mode_is_illegal(in_mode);
    assign v_s[0]     = in_valid;
    assign data_s[0]  = in_data;
    assign amt_s[0]   = in_illegal ? '0 : in_amt;
    assign mode_s[0]  = in_mode;
    assign err_s[0]   = in_illegal;

    genvar k;
    generate
        for (k = 0; k < AMT_W; k++) begin : g_stage
            logic load_k;
            logic next_take;

            if (k == AMT_W - 1) begin : g_last
                assign next_take = out_ready;
            end else begin : g_mid
                assign next_take = g_stage[k+1].load_k;
            end

            shift_stage #(
                .WIDTH (WIDTH),
                .STEP  (1 << k),
                .AMT_W (AMT_W)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .prev_valid (v_s[k]),
                .prev_data  (data_s[k]),
                .prev_amt   (amt_s[k]),
                .prev_mode  (mode_s[k]),
                .prev_err   (err_s[k]),
                .next_take  (next_take),
                .load       (load_k),
                .valid      (v_s[k+1]),
                .data       (data_s[k+1]),
                .amt        (amt_s[k+1]),
                .mode       (mode_s[k+1]),
                .err        (err_s[k+1])
            );
        end
    endgenerate

    assign in_ready  = g_stage[0].load_k;
    assign out_valid = v_s[AMT_W];
    assign out_data  = data_s[AMT_W];
    assign out_err   = err_s[AMT_W];

    // Amount and mode are spent once the word leaves the last stage.
    assign unused_tail = ^{amt_s[AMT_W], mode_s[AMT_W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed checks on WIDTH=8 plus a random
// regression on WIDTH=2, 8 and 32 against a bit-level reference model.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int w_of [3] = '{2, 8, 32};

    logic        r_valid  [3];
    logic        r_oready [3];
    logic [63:0] r_data   [3];
    logic [4:0]  r_amt    [3];
    logic [2:0]  r_mode   [3];
    logic        s_iready [3];
    logic        s_ovalid [3];
    logic        s_oerr   [3];
    logic [1:0]  od2;
    logic [7:0]  od8;
    logic [31:0] od32;

    logic [64:0] sb [3][0:4095];
    int hd [3];
    int tl [3];

    pipelined_barrel_shifter #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_valid[0]), .in_ready(s_iready[0]),
        .in_data(r_data[0][1:0]), .in_amt(r_amt[0][0:0]), .in_mode(r_mode[0]),
        .out_valid(s_ovalid[0]), .out_ready(r_oready[0]), .out_data(od2), .out_err(s_oerr[0]));

    pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_valid[1]), .in_ready(s_iready[1]),
        .in_data(r_data[1][7:0]), .in_amt(r_amt[1][2:0]), .in_mode(r_mode[1]),
        .out_valid(s_ovalid[1]), .out_ready(r_oready[1]), .out_data(od8), .out_err(s_oerr[1]));

    pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(r_valid[2]), .in_ready(s_iready[2]),
        .in_data(r_data[2][31:0]), .in_amt(r_amt[2]), .in_mode(r_mode[2]),
        .out_valid(s_ovalid[2]), .out_ready(r_oready[2]), .out_data(od32), .out_err(s_oerr[2]));

    function automatic logic [63:0] out_d(input int i);
        case (i)
            0:       return {62'b0, od2};
            1:       return {56'b0, od8};
            default: return {32'b0, od32};
        endcase
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    // Result bit i is picked from the source position the shift moves into it.
    function automatic logic [64:0] ref_model(input logic [63:0] d, input int amt,
                                              input int mode, input int w);
        logic [63:0] r;
        r = '0;
        if (mode > 4) return {1'b1, d};
        for (int i = 0; i < w; i++) begin
            case (mode)
                0:       r[i] = d[(i + amt) % w];
                1:       r[i] = d[(i - amt + w) % w];
                2:       r[i] = (i + amt < w) ? d[i + amt] : 1'b0;
                3:       r[i] = (i >= amt) ? d[i - amt] : 1'b0;
                default: r[i] = (i + amt < w) ? d[i + amt] : d[w - 1];
            endcase
        end
        return {1'b0, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            r_valid[i] = 1'b0; r_oready[i] = 1'b1;
            r_data[i] = '0; r_amt[i] = '0; r_mode[i] = '0;
        end
    endtask

    task automatic test_reset();
        idle_all();
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (s_ovalid[i] !== 1'b0 || out_d(i) !== 64'd0 || s_oerr[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs dut=%0d valid=%b data=%h err=%b want 0/0/0",
                         i, s_ovalid[i], out_d(i), s_oerr[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (s_iready[i] !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready dut=%0d got=%b want=1", i, s_iready[i]);
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0] td [7];
        int         ta [7];
        int         tm [7];
        logic [7:0] te [7];
        logic       tr [7];
        int         n;
        td = '{8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'h5A, 8'h5A};
        ta = '{1, 3, 2, 2, 4, 5, 0};
        tm = '{0, 1, 2, 4, 3, 6, 0};
        te = '{8'hD8, 8'h8D, 8'h2C, 8'hEC, 8'h10, 8'h5A, 8'h5A};
        tr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        r_oready[1] = 1'b1;
        for (int j = 0; j < 7; j++) begin
            r_valid[1] = 1'b1;
            r_data[1]  = {56'b0, td[j]};
            r_amt[1]   = 5'(ta[j]);
            r_mode[1]  = 3'(tm[j]);
            @(negedge clk);
            total++;
            if (s_iready[1] !== 1'b1) begin
                bad++;
                $display("FAIL mode_accept case=%0d in_ready=%b want=1", j, s_iready[1]);
            end
            step();
            r_valid[1] = 1'b0;
            n = 1;
            while (!s_ovalid[1] && n < 10) begin
                step();
                n++;
            end
            total++;
            if (n !== 3) begin
                bad++;
                $display("FAIL mode_latency case=%0d got=%0d want=3", j, n);
            end
            total++;
            if (od8 !== te[j] || s_oerr[1] !== tr[j]) begin
                bad++;
                $display("FAIL mode_result case=%0d got=%h err=%b want=%h err=%b",
                         j, od8, s_oerr[1], te[j], tr[j]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [64:0] q [$];
        logic [64:0] e;
        logic [7:0]  hold;
        int acc, got, first_c, last_c;
        acc = 0; got = 0; first_c = -1; last_c = -1; hold = '0;
        r_oready[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            r_valid[1] = 1'b1;
            r_data[1]  = {56'b0, 8'($urandom)};
            r_amt[1]   = 5'(acc % 8);
            r_mode[1]  = 3'(acc % 5);
            @(negedge clk);
            if (s_iready[1]) begin
                q.push_back(ref_model(r_data[1], int'(r_amt[1]), int'(r_mode[1]), 8));
                acc++;
            end
            if (c == 5) hold = od8;
            step();
        end
        total++;
        if (acc !== 3) begin
            bad++;
            $display("FAIL bp_accepts got=%0d want=3", acc);
        end
        total++;
        if (s_iready[1] !== 1'b0 || s_ovalid[1] !== 1'b1) begin
            bad++;
            $display("FAIL bp_full in_ready=%b out_valid=%b want 0/1", s_iready[1], s_ovalid[1]);
        end
        total++;
        if (od8 !== hold) begin
            bad++;
            $display("FAIL bp_hold got=%h want=%h", od8, hold);
        end
        r_oready[1] = 1'b1;
        for (int c = 0; c < 40 && got < 10; c++) begin
            r_valid[1] = (acc < 10);
            r_data[1]  = {56'b0, 8'($urandom)};
            r_amt[1]   = 5'($urandom_range(0, 7));
            r_mode[1]  = 3'($urandom_range(0, 4));
            @(negedge clk);
            if (s_ovalid[1] && r_oready[1]) begin
                e = (q.size() > 0) ? q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
                total++;
                if ({s_oerr[1], 56'b0, od8} !== e) begin
                    bad++;
                    $display("FAIL bp_order idx=%0d got=%h want=%h", got, od8, e[7:0]);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            if (r_valid[1] && s_iready[1]) begin
                q.push_back(ref_model(r_data[1], int'(r_amt[1]), int'(r_mode[1]), 8));
                acc++;
            end
            step();
        end
        r_valid[1] = 1'b0;
        total++;
        if (got !== 10 || last_c - first_c !== 9) begin
            bad++;
            $display("FAIL bp_drain got=%0d span=%0d want 10/9", got, last_c - first_c);
        end
    endtask

    task automatic test_bubble();
        logic [64:0] q [$];
        logic [64:0] e;
        logic [9:0]  pat;
        int got;
        pat = 10'b00_0010_1001;
        got = 0;
        r_oready[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            r_valid[1] = pat[c];
            r_data[1]  = {56'b0, 8'($urandom)};
            r_amt[1]   = 5'($urandom_range(0, 7));
            r_mode[1]  = 3'($urandom_range(0, 4));
            @(negedge clk);
            if (r_valid[1] && s_iready[1])
                q.push_back(ref_model(r_data[1], int'(r_amt[1]), int'(r_mode[1]), 8));
            step();
        end
        r_valid[1] = 1'b0;
        total++;
        if (q.size() !== 3 || s_iready[1] !== 1'b0) begin
            bad++;
            $display("FAIL bubble_fill accepted=%0d in_ready=%b want 3/0", q.size(), s_iready[1]);
        end
        r_oready[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s_ovalid[1]) begin
                e = (q.size() > 0) ? q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
                total++;
                if ({s_oerr[1], 56'b0, od8} !== e) begin
                    bad++;
                    $display("FAIL bubble_order idx=%0d got=%h want=%h", got, od8, e[7:0]);
                end
                got++;
            end
            step();
        end
        total++;
        if (got !== 3) begin
            bad++;
            $display("FAIL bubble_count got=%0d want=3", got);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        r_oready[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            r_valid[1] = 1'b1;
            r_data[1]  = {56'b0, 8'hC3};
            r_amt[1]   = 5'(c);
            r_mode[1]  = 3'd1;
            step();
        end
        r_valid[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (s_ovalid[1] !== 1'b0 || od8 !== 8'h00 || s_oerr[1] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs valid=%b data=%h err=%b want 0/00/0",
                     s_ovalid[1], od8, s_oerr[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (s_iready[1] !== 1'b1) begin
            bad++;
            $display("FAIL midreset_in_ready got=%b want=1", s_iready[1]);
        end
        r_oready[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (s_ovalid[1]) seen++;
            step();
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_stale got=%0d outputs want=0", seen);
        end
    endtask

    task automatic test_random();
        logic [64:0] e;
        for (int i = 0; i < 3; i++) begin
            hd[i] = 0; tl[i] = 0;
        end
        for (int c = 0; c < 2010; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (c < 2000) begin
                    r_valid[i]  = ($urandom_range(0, 3) != 0);
                    r_oready[i] = ($urandom_range(0, 3) != 0);
                end else begin
                    r_valid[i]  = 1'b0;
                    r_oready[i] = 1'b1;
                end
                r_data[i] = {$urandom, $urandom} & wmask(w_of[i]);
                r_amt[i]  = 5'($urandom_range(0, w_of[i] - 1));
                r_mode[i] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                         : 3'($urandom_range(0, 4));
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (s_ovalid[i] && r_oready[i]) begin
                    total++;
                    if (hd[i] == tl[i]) begin
                        bad++;
                        $display("FAIL rand_extra dut=%0d got=%h", i, out_d(i));
                    end else begin
                        e = sb[i][hd[i] % 4096];
                        hd[i]++;
                        if ({s_oerr[i], out_d(i)} !== e) begin
                            bad++;
                            $display("FAIL rand_data dut=%0d got=%h err=%b want=%h err=%b",
                                     i, out_d(i), s_oerr[i], e[63:0], e[64]);
                        end
                    end
                end
                if (r_valid[i] && s_iready[i]) begin
                    sb[i][tl[i] % 4096] = ref_model(r_data[i], int'(r_amt[i]),
                                                    int'(r_mode[i]), w_of[i]);
                    tl[i]++;
                end
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (hd[i] != tl[i] || tl[i] < 100) begin
                bad++;
                $display("FAIL rand_drain dut=%0d delivered=%0d accepted=%0d", i, hd[i], tl[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_bubble();
        test_reset_mid();
        idle_all();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
